// File: rtl/vx_mem_line_splitter.sv
// vx_mem_line_splitter: splits line-wide memory requests into RATIO narrow beats
// and reassembles in-order read beats into tagged line responses. Writes are posted.
// Optional build macro: VX_MEM_SPLIT_SKIP_EMPTY_EN (skip write beats whose byteen slice is zero).
module vx_mem_line_splitter #(
   parameter int unsigned LINE_W      = 512,
   parameter int unsigned BEAT_W      = 128,
   parameter int unsigned ADDR_W      = 26,
   parameter int unsigned TAG_W       = 8,
   parameter int unsigned MAX_PENDING = 8
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         up_req_valid,
   input  logic                                         up_req_rw,
   input  logic [LINE_W/8-1:0]                          up_req_byteen,
   input  logic [ADDR_W-1:0]                            up_req_addr,
   input  logic [LINE_W-1:0]                            up_req_data,
   input  logic [TAG_W-1:0]                             up_req_tag,
   output logic                                         up_req_ready,
   output logic                                         up_rsp_valid,
   output logic [LINE_W-1:0]                            up_rsp_data,
   output logic [TAG_W-1:0]                             up_rsp_tag,
   input  logic                                         up_rsp_ready,
   output logic                                         dn_req_valid,
   output logic                                         dn_req_rw,
   output logic [BEAT_W/8-1:0]                          dn_req_byteen,
   output logic [ADDR_W+$clog2(LINE_W/BEAT_W)-1:0]      dn_req_addr,
   output logic [BEAT_W-1:0]                            dn_req_data,
   input  logic                                         dn_req_ready,
   input  logic                                         dn_rsp_valid,
   input  logic [BEAT_W-1:0]                            dn_rsp_data,
   output logic                                         dn_rsp_ready,
   output logic                                         busy
);

   localparam int unsigned RATIO  = LINE_W / BEAT_W;
   localparam int unsigned CNT_W  = $clog2(RATIO);
   localparam int unsigned BEAT_B = BEAT_W / 8;
   localparam int unsigned LINE_B = LINE_W / 8;
   localparam int unsigned PTR_W  = $clog2(MAX_PENDING);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state;
   logic                line_rw;
   logic [ADDR_W-1:0]   line_addr;
   logic [LINE_W-1:0]   line_data;
   logic [LINE_B-1:0]   line_byteen;
   logic [CNT_W-1:0]    beat_cnt;

   logic [TAG_W-1:0]    tag_mem [MAX_PENDING];
   logic [PTR_W:0]      wr_ptr;
   logic [PTR_W:0]      rd_ptr;
   logic                tagq_empty;
   logic                tagq_full;

   logic [CNT_W-1:0]    rsp_cnt;
   logic [LINE_W-1:0]   rsp_buf;

   logic                can_acc;
   logic                last_beat;
   logic [CNT_W-1:0]    next_cnt;
   logic [CNT_W-1:0]    first_cnt;
   logic                drop_line;
   logic                up_fire;
   logic                dn_fire;
   logic                rsp_fire;
   logic                tag_push;
   logic                tag_pop;

   assign tagq_empty = (wr_ptr == rd_ptr);
   assign tagq_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign can_acc      = up_req_rw | ~tagq_full;
   assign up_req_ready = can_acc & ((state == IDLE) |
                                    ((state == SEND) & last_beat & dn_req_ready));
   assign up_fire      = up_req_valid & up_req_ready;
   assign dn_fire      = dn_req_valid & dn_req_ready;
   assign tag_push     = up_fire & ~up_req_rw;
   assign tag_pop      = up_rsp_valid & up_rsp_ready;

   assign dn_req_valid  = (state == SEND);
   assign dn_req_rw     = line_rw;
   assign dn_req_addr   = {line_addr, beat_cnt};
   assign dn_req_data   = line_data[beat_cnt*BEAT_W +: BEAT_W];
   assign dn_req_byteen = line_byteen[beat_cnt*BEAT_B +: BEAT_B];

   assign dn_rsp_ready = ~up_rsp_valid;
   assign rsp_fire     = dn_rsp_valid & dn_rsp_ready;
   assign up_rsp_data  = rsp_buf;

   assign busy = (state != IDLE) | ~tagq_empty | up_rsp_valid;

   // Beat sequencing: next beat index, last-beat detect, first beat of an incoming line.
   always_comb begin
      last_beat = (beat_cnt == CNT_W'(RATIO - 1));
      next_cnt  = beat_cnt + CNT_W'(1);
      first_cnt = '0;
      drop_line = 1'b0;
`ifdef VX_MEM_SPLIT_SKIP_EMPTY_EN
      // Writes hop over beats with an all-zero byteen slice; descending scan keeps the lowest hit.
      if (line_rw) begin
         last_beat = 1'b1;
         for (int i = int'(RATIO) - 1; i >= 0; i--) begin
            if (i > int'(beat_cnt) && |line_byteen[i*BEAT_B +: BEAT_B]) begin
               last_beat = 1'b0;
               next_cnt  = CNT_W'(i);
            end
         end
      end
      if (up_req_rw) begin
         drop_line = 1'b1;
         for (int i = int'(RATIO) - 1; i >= 0; i--) begin
            if (|up_req_byteen[i*BEAT_B +: BEAT_B]) begin
               drop_line = 1'b0;
               first_cnt = CNT_W'(i);
            end
         end
      end
`endif
   end

   // Request FSM: latch an accepted line, then stream its beats downstream.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         beat_cnt    <= '0;
         line_rw     <= 1'b0;
         line_addr   <= '0;
         line_data   <= '0;
         line_byteen <= '0;
      end else if (up_fire) begin
         line_rw     <= up_req_rw;
         line_addr   <= up_req_addr;
         line_data   <= up_req_data;
         line_byteen <= up_req_byteen;
         beat_cnt    <= first_cnt;
         state       <= drop_line ? IDLE : SEND;
      end else if (dn_fire) begin
         if (last_beat) begin
            state    <= IDLE;
            beat_cnt <= '0;
         end else begin
            beat_cnt <= next_cnt;
         end
      end
   end

   // Tag FIFO pointers; one entry per outstanding read line.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (tag_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (tag_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Tag FIFO storage; contents are don't-care once the pointers reset.
   always_ff @(posedge clk) begin
      if (tag_push) tag_mem[wr_ptr[PTR_W-1:0]] <= up_req_tag;
   end

   // Response assembly: collect RATIO beats, then present the line with the head tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_cnt      <= '0;
         rsp_buf      <= '0;
         up_rsp_valid <= 1'b0;
         up_rsp_tag   <= '0;
      end else begin
         if (rsp_fire) begin
            rsp_buf[rsp_cnt*BEAT_W +: BEAT_W] <= dn_rsp_data;
            rsp_cnt <= rsp_cnt + CNT_W'(1);
            if (rsp_cnt == CNT_W'(RATIO - 1)) begin
               up_rsp_valid <= 1'b1;
               up_rsp_tag   <= tag_mem[rd_ptr[PTR_W-1:0]];
            end
         end
         if (tag_pop) up_rsp_valid <= 1'b0;
      end
   end

`ifndef SYNTHESIS
   // A read beat with no pending read line means the controller returned stray data.
   a_rsp_has_tag: assert property (@(posedge clk) disable iff (reset)
      dn_rsp_valid |-> !tagq_empty)
      else $error("dn_rsp_valid with empty tag FIFO");

   // Upstream must hold a stalled request stable.
   a_req_stable: assert property (@(posedge clk) disable iff (reset)
      (up_req_valid && !up_req_ready) |=>
         (up_req_valid && $stable(up_req_rw) && $stable(up_req_byteen) &&
          $stable(up_req_addr) && $stable(up_req_data) && $stable(up_req_tag)))
      else $error("up_req changed while stalled");
`endif

endmodule

// File: tb/tb_vx_mem_line_splitter.sv
// Testbench for vx_mem_line_splitter: scoreboard of expected beats and responses
// built from line-level rules, with a simple in-order memory model downstream.
module tb_vx_mem_line_splitter;

   localparam int unsigned LINE_W      = 512;
   localparam int unsigned BEAT_W      = 128;
   localparam int unsigned ADDR_W      = 26;
   localparam int unsigned TAG_W       = 8;
   localparam int unsigned MAX_PENDING = 4;
   localparam int unsigned RATIO       = LINE_W / BEAT_W;
   localparam int unsigned CNT_W       = 2;
   localparam int unsigned DA_W        = ADDR_W + CNT_W;
   localparam int unsigned BB          = BEAT_W / 8;
   localparam int unsigned LB          = LINE_W / 8;
   localparam int unsigned REC_W       = 1 + DA_W + BB + BEAT_W;
`ifdef VX_MEM_SPLIT_SKIP_EMPTY_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic              clk;
   logic              reset;
   logic              up_req_valid;
   logic              up_req_rw;
   logic [LB-1:0]     up_req_byteen;
   logic [ADDR_W-1:0] up_req_addr;
   logic [LINE_W-1:0] up_req_data;
   logic [TAG_W-1:0]  up_req_tag;
   logic              up_req_ready;
   logic              up_rsp_valid;
   logic [LINE_W-1:0] up_rsp_data;
   logic [TAG_W-1:0]  up_rsp_tag;
   logic              up_rsp_ready;
   logic              dn_req_valid;
   logic              dn_req_rw;
   logic [BB-1:0]     dn_req_byteen;
   logic [DA_W-1:0]   dn_req_addr;
   logic [BEAT_W-1:0] dn_req_data;
   logic              dn_req_ready;
   logic              dn_rsp_valid;
   logic [BEAT_W-1:0] dn_rsp_data;
   logic              dn_rsp_ready;
   logic              busy;

   vx_mem_line_splitter #(
      .LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MAX_PENDING(MAX_PENDING)
   ) dut (
      .clk(clk), .reset(reset),
      .up_req_valid(up_req_valid), .up_req_rw(up_req_rw), .up_req_byteen(up_req_byteen),
      .up_req_addr(up_req_addr), .up_req_data(up_req_data), .up_req_tag(up_req_tag),
      .up_req_ready(up_req_ready),
      .up_rsp_valid(up_rsp_valid), .up_rsp_data(up_rsp_data), .up_rsp_tag(up_rsp_tag),
      .up_rsp_ready(up_rsp_ready),
      .dn_req_valid(dn_req_valid), .dn_req_rw(dn_req_rw), .dn_req_byteen(dn_req_byteen),
      .dn_req_addr(dn_req_addr), .dn_req_data(dn_req_data), .dn_req_ready(dn_req_ready),
      .dn_rsp_valid(dn_rsp_valid), .dn_rsp_data(dn_rsp_data), .dn_rsp_ready(dn_rsp_ready),
      .busy(busy)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [REC_W-1:0]        exp_beats [$];
   logic [TAG_W+LINE_W-1:0] exp_rsp   [$];
   logic [BEAT_W-1:0]       mem_q     [$];
   int                      fire_cyc  [$];
   bit rsp_en      = 1'b1;
   bit req_rdy_all = 1'b0;
   bit rec_fire    = 1'b0;
   int beats_seen    = 0;
   int first_pop_cyc = -1;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Downstream memory contents: a fixed function of the beat address.
   function automatic logic [BEAT_W-1:0] mem_word(input logic [DA_W-1:0] a);
      logic [31:0] x;
      x = {4'h0, a};
      return {x ^ 32'hA5A5_5A5A, x * 32'h9E37_79B1, ~x, x + 32'h1234_5678};
   endfunction

   // Expected traffic for one accepted line.
   function automatic void model_push(input logic rw, input logic [ADDR_W-1:0] addr,
                                      input logic [LB-1:0] be, input logic [LINE_W-1:0] data,
                                      input logic [TAG_W-1:0] tag);
      logic [LINE_W-1:0] line;
      logic [DA_W-1:0]   ba;
      line = '0;
      for (int i = 0; i < int'(RATIO); i++) begin
         ba = {addr, CNT_W'(i)};
         if (!(rw && SKIP && be[i*BB +: BB] == '0))
            exp_beats.push_back({rw, ba, be[i*BB +: BB], data[i*BEAT_W +: BEAT_W]});
         line[i*BEAT_W +: BEAT_W] = mem_word(ba);
      end
      if (!rw) exp_rsp.push_back({tag, line});
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

   // Monitor: handshakes seen at the falling edge fire on the following rising edge.
   initial forever begin
      logic [TAG_W+LINE_W-1:0] e;
      @(negedge clk);
      if (reset) begin
         exp_beats.delete();
         exp_rsp.delete();
         mem_q.delete();
      end else begin
         if (up_req_valid && up_req_ready)
            model_push(up_req_rw, up_req_addr, up_req_byteen, up_req_data, up_req_tag);
         if (dn_rsp_valid && dn_rsp_ready && mem_q.size() > 0) void'(mem_q.pop_front());
         if (dn_req_valid && dn_req_ready) begin
            beats_seen++;
            if (rec_fire) fire_cyc.push_back(cyc);
            if (exp_beats.size() == 0)
               check("dn_unexpected", 512'({dn_req_rw, dn_req_addr}), 512'(0));
            else
               check("dn_beat", 512'({dn_req_rw, dn_req_addr, dn_req_byteen, dn_req_data}),
                     512'(exp_beats.pop_front()));
            if (!dn_req_rw) mem_q.push_back(mem_word(dn_req_addr));
         end
         if (up_rsp_valid && up_rsp_ready) begin
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            if (exp_rsp.size() == 0) begin
               check("rsp_unexpected", 512'(up_rsp_tag), 512'(0));
            end else begin
               e = exp_rsp.pop_front();
               check("rsp_tag", 512'(up_rsp_tag), 512'(e[TAG_W+LINE_W-1:LINE_W]));
               check("rsp_data", up_rsp_data, e[LINE_W-1:0]);
            end
         end
      end
   end

   // Downstream controller and upstream consumer with random back-pressure.
   initial begin
      dn_req_ready = 1'b0;
      dn_rsp_valid = 1'b0;
      dn_rsp_data  = '0;
      up_rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         dn_req_ready = req_rdy_all ? 1'b1 : ($urandom_range(0, 3) != 0);
         up_rsp_ready = ($urandom_range(0, 3) != 0);
         if (rsp_en && !reset && mem_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            dn_rsp_valid = 1'b1;
            dn_rsp_data  = mem_q[0];
         end else begin
            dn_rsp_valid = 1'b0;
         end
      end
   end

   // Present one line and hold it until accepted; called just after a rising edge.
   task automatic send_line(input logic rw, input logic [ADDR_W-1:0] addr, input logic [LB-1:0] be,
                            input logic [LINE_W-1:0] data, input logic [TAG_W-1:0] tag);
      bit done;
      int n;
      up_req_valid  = 1'b1;
      up_req_rw     = rw;
      up_req_addr   = addr;
      up_req_byteen = be;
      up_req_data   = data;
      up_req_tag    = tag;
      done = 1'b0;
      n    = 0;
      while (!done) begin
         @(negedge clk);
         if (up_req_ready) done = 1'b1;
         else if (++n > 1000) begin
            check("req_accept_timeout", 512'(0), 512'(1));
            done = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      up_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 3000 && !ok; n++) begin
         @(negedge clk);
         if (!busy && !dn_req_valid && exp_beats.size() == 0 && exp_rsp.size() == 0) ok = 1'b1;
      end
      check("drain", 512'(ok), 512'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [LB-1:0] be;
      bit blocked;
      int n0;
      int acc_cyc;
      reset         = 1'b1;
      up_req_valid  = 1'b0;
      up_req_rw     = 1'b0;
      up_req_addr   = '0;
      up_req_byteen = '0;
      up_req_data   = '0;
      up_req_tag    = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_dn_req_valid", 512'(dn_req_valid), 512'(0));
      check("rst_up_rsp_valid", 512'(up_rsp_valid), 512'(0));
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_up_req_ready", 512'(up_req_ready), 512'(1));
      check("rst_dn_rsp_ready", 512'(dn_rsp_ready), 512'(1));
      @(posedge clk);
      #1;

      // Directed read and write
      send_line(1'b0, 26'h10, '1, rand_line(), 8'h05);
      wait_idle();
      send_line(1'b1, 26'h2, '1, rand_line(), 8'h11);
      wait_idle();

      // Tag FIFO full: reads stall, writes still pass
      rsp_en = 1'b0;
      for (int i = 0; i < 4; i++) send_line(1'b0, ADDR_W'(32'h100 + i), '1, rand_line(), TAG_W'(i + 8'h20));
      send_line(1'b1, 26'h200, '1, rand_line(), 8'h77);
      check("full_no_rsp", 512'(up_rsp_valid), 512'(0));
      up_req_valid  = 1'b1;
      up_req_rw     = 1'b0;
      up_req_addr   = 26'h104;
      up_req_byteen = '1;
      up_req_data   = rand_line();
      up_req_tag    = 8'h24;
      blocked = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (up_req_ready) blocked = 1'b0;
      end
      check("full_blocks_read", 512'(blocked), 512'(1));
      check("full_busy", 512'(busy), 512'(1));
      first_pop_cyc = -1;
      rsp_en = 1'b1;
      acc_cyc = -1;
      for (int n = 0; n < 1000 && acc_cyc < 0; n++) begin
         @(negedge clk);
         if (up_req_ready) acc_cyc = cyc;
      end
      check("full_accept_after_pop", 512'(acc_cyc > first_pop_cyc && first_pop_cyc >= 0), 512'(1));
      @(posedge clk);
      #1;
      up_req_valid = 1'b0;
      wait_idle();

      // Back-to-back reads at full downstream throughput
      req_rdy_all = 1'b1;
      fire_cyc.delete();
      rec_fire = 1'b1;
      send_line(1'b0, 26'h3A0, '1, rand_line(), 8'hA1);
      send_line(1'b0, 26'h3A1, '1, rand_line(), 8'hA2);
      wait_idle();
      rec_fire = 1'b0;
      req_rdy_all = 1'b0;
      check("tp_beats", 512'(fire_cyc.size()), 512'(8));
      if (fire_cyc.size() == 8) check("tp_span", 512'(fire_cyc[7] - fire_cyc[0]), 512'(7));

      // Sparse byte enables
      n0 = beats_seen;
      be = 64'h0000_FFFF_0000_0000;
      send_line(1'b1, 26'h33, be, rand_line(), 8'h01);
      wait_idle();
      check("sparse_beats", 512'(beats_seen - n0), 512'(SKIP ? 1 : 4));
      n0 = beats_seen;
      send_line(1'b1, 26'h34, '0, rand_line(), 8'h02);
      wait_idle();
      check("zero_be_beats", 512'(beats_seen - n0), 512'(SKIP ? 0 : 4));

      // Reset in the middle of a write
      req_rdy_all = 1'b1;
      send_line(1'b1, 26'h7, '1, rand_line(), 8'h03);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_dn_valid", 512'(dn_req_valid), 512'(0));
      check("midrst_busy", 512'(busy), 512'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_rdy_all = 1'b0;
      send_line(1'b1, 26'h9, '1, rand_line(), 8'h04);
      wait_idle();

      // Random traffic
      for (int k = 0; k < 80; k++) begin
         case ($urandom_range(0, 2))
            0: be = '1;
            1: be = {$urandom, $urandom};
            default: begin
               be = {$urandom, $urandom};
               for (int i = 0; i < int'(RATIO); i++)
                  if ($urandom_range(0, 1) == 0) be[i*BB +: BB] = '0;
            end
         endcase
         send_line(1'($urandom_range(0, 1)), ADDR_W'($urandom), be, rand_line(), TAG_W'($urandom));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
         #1;
      end
      wait_idle();
      check("end_busy", 512'(busy), 512'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
